battle_sequencer: RTL and testbench
===================================

Name: battle_sequencer

Overview:
- Top-level turn controller for the battle screen. Drives the 4-bit state code consumed by the phase blocks: the player attack-bar block and the enemy/dodge block.
- Collects each phase's busy/finished handshake and damage result, maintains both HP counters, and decides win/lose.
- Applies state changes only at frame start (hcount=0, vcount=0), so no phase block ever sees a state switch mid-frame.

Parameters:
PLAYER_HP_INIT, 100, player HP loaded at reset/new game (8-bit)
ENEMY_HP_INIT, 200, enemy HP loaded at reset/new game (8-bit)
TIMEOUT_FRAMES, 600, max frames a phase may stay busy before forced finish
MENU_FRAMES, 30, minimum frames MENU is held before confirm_in is accepted

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (rst=0 resets on the rising clk edge)
hcount_in  in  11  pixel x counter
vcount_in  in  10  pixel y counter
start_in  in  1  single-cycle pulse: start/restart game
confirm_in  in  1  single-cycle pulse: confirm attack in MENU
atk_finished_in  in  1  single-cycle pulse from the attack phase block
atk_damage_in  in  8  damage to enemy; valid only with atk_finished_in
dodge_finished_in  in  1  single-cycle pulse from the enemy/dodge phase block
dodge_damage_in  in  8  damage to player; valid only with dodge_finished_in
state_out  out  4  current state code broadcast to phase blocks
player_hp_out  out  8  current player HP
enemy_hp_out  out  8  current enemy HP
win_out  out  1  high while in WIN
lose_out  out  1  high while in LOSE

Behaviour:
- frame_start = (hcount_in==0 && vcount_in==0). All state_out changes take effect only on the cycle where frame_start=1.
- Internal next_q holds the pending state and is written by events. On frame_start, state_out <= next_q.
- State encodings:
  - IDLE=4'b0000
  - ATTACK=4'b0001
  - DODGE=4'b0010
  - MENU=4'b0100
  - WIN=4'b1000
  - LOSE=4'b1001
- Reset (rst=0):
  - state_out=IDLE, next_q=IDLE.
  - player_hp_out=PLAYER_HP_INIT, enemy_hp_out=ENEMY_HP_INIT.
  - win_out=0, lose_out=0, frame counter=0.
- IDLE: start_in -> reload both HP counters, next_q=MENU.
- MENU: frame counter counts frame_starts. confirm_in is ignored until counter>=MENU_FRAMES; after that, confirm_in -> next_q=ATTACK.
- ATTACK:
  - on atk_finished_in, enemy_hp <= enemy_hp - atk_damage_in, saturating at 0.
  - if the result is 0, next_q=WIN; otherwise next_q=DODGE.
- DODGE:
  - on dodge_finished_in, player_hp saturates the same way.
  - if the result is 0, next_q=LOSE; otherwise next_q=MENU.
- WIN/LOSE: the matching flag is held high. start_in -> reload HP, next_q=MENU.
- The frame counter clears on every state_out change. It increments on frame_start while state_out is unchanged.
- Timeout: in ATTACK or DODGE, if the counter reaches TIMEOUT_FRAMES with no finished pulse, the phase is treated as finished with damage 0.
- Only one transition event is accepted per state_out value: once next_q != state_out, further finished/confirm pulses are ignored until the switch.
- A finished pulse arriving while state_out does not match that phase is ignored: no HP change.
- Event and frame_start in the same cycle:
  - the HP update happens on that cycle;
  - next_q updates on that cycle;
  - state_out picks up the new value at the next frame_start, not this one.
- start_in outside IDLE/WIN/LOSE is ignored.
- Reset mid-phase returns to IDLE at once, without waiting for frame_start.
- All arithmetic is 8-bit unsigned. Subtraction is computed 9-bit, and the result is clamped to 0 on borrow.

Test Plan:
1. Reset with rst=0 for 2 cycles -> state_out=0000, HP outputs=100/200, win_out=0, lose_out=0.
2. start_in in IDLE at mid-frame -> state_out stays 0000 until the next frame_start, then becomes 0100. confirm_in at frame 5 is ignored. confirm_in after 30 frames -> ATTACK (0001) at the following frame start.
3. In ATTACK, atk_finished_in with damage=50 -> enemy_hp_out=150; state_out=0010 at the next frame start. Then dodge_finished_in with damage=30 -> player_hp_out=70, state_out=0100.
4. enemy_hp=20 and damage=255 -> enemy_hp_out=0, state_out=1000, win_out=1. start_in -> HP outputs=100/200, state_out=0100.
5. ATTACK with no finished pulse for 600 frames -> enemy HP unchanged, state_out=0010 at the next frame start. A stray atk_finished_in during DODGE -> no HP change.
6. Two atk_finished_in pulses (damage 10, then 10) before the frame switch -> only the first applies (enemy_hp_out=190). rst=0 in DODGE -> immediate IDLE.

Source files
------------

// File: rtl/battle_sequencer.sv
// Battle-screen turn controller: sequences IDLE/MENU/ATTACK/DODGE/WIN/LOSE,
// keeps both HP counters and only switches the broadcast state at frame start.
module battle_sequencer #(
   parameter logic [7:0] PLAYER_HP_INIT = 8'd100,
   parameter logic [7:0] ENEMY_HP_INIT  = 8'd200,
   parameter int         TIMEOUT_FRAMES = 600,
   parameter int         MENU_FRAMES    = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        start_in,
   input  logic        confirm_in,
   input  logic        atk_finished_in,
   input  logic [7:0]  atk_damage_in,
   input  logic        dodge_finished_in,
   input  logic [7:0]  dodge_damage_in,
   output logic [3:0]  state_out,
   output logic [7:0]  player_hp_out,
   output logic [7:0]  enemy_hp_out,
   output logic        win_out,
   output logic        lose_out
);

   typedef enum logic [3:0] {
      IDLE   = 4'b0000,
      ATTACK = 4'b0001,
      DODGE  = 4'b0010,
      MENU   = 4'b0100,
      WIN    = 4'b1000,
      LOSE   = 4'b1001
   } state_t;

   localparam int CNT_MAX = (TIMEOUT_FRAMES > MENU_FRAMES) ? TIMEOUT_FRAMES : MENU_FRAMES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);
   localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT_FRAMES);
   localparam logic [CW-1:0] MENU_C    = CW'(MENU_FRAMES);

   state_t        state_q, next_q, pend_d;
   logic [7:0]    player_hp, enemy_hp, player_hp_d, enemy_hp_d;
   logic [CW-1:0] frames;
   logic          frame_start, settled, timed_out;
   logic [7:0]    dmg;
   logic [8:0]    diff;

   assign frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);
   // one accepted event per displayed state: nothing new until the switch lands
   assign settled     = (next_q == state_q);
   assign timed_out   = (frames >= TIMEOUT_C);

   always_comb begin
      pend_d      = next_q;
      player_hp_d = player_hp;
      enemy_hp_d  = enemy_hp;
      dmg         = 8'd0;
      diff        = 9'd0;
      if (settled) begin
         case (state_q)
            IDLE, WIN, LOSE: begin
               if (start_in) begin
                  player_hp_d = PLAYER_HP_INIT;
                  enemy_hp_d  = ENEMY_HP_INIT;
                  pend_d      = MENU;
               end
            end
            MENU: begin
               if (confirm_in && (frames >= MENU_C)) pend_d = ATTACK;
            end
            ATTACK: begin
               if (atk_finished_in || timed_out) begin
                  dmg        = atk_finished_in ? atk_damage_in : 8'd0;
                  diff       = {1'b0, enemy_hp} - {1'b0, dmg};
                  enemy_hp_d = diff[8] ? 8'd0 : diff[7:0];
                  pend_d     = (enemy_hp_d == 8'd0) ? WIN : DODGE;
               end
            end
            DODGE: begin
               if (dodge_finished_in || timed_out) begin
                  dmg         = dodge_finished_in ? dodge_damage_in : 8'd0;
                  diff        = {1'b0, player_hp} - {1'b0, dmg};
                  player_hp_d = diff[8] ? 8'd0 : diff[7:0];
                  pend_d      = (player_hp_d == 8'd0) ? LOSE : MENU;
               end
            end
            default: pend_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         next_q    <= IDLE;
         player_hp <= PLAYER_HP_INIT;
         enemy_hp  <= ENEMY_HP_INIT;
         frames    <= '0;
      end else begin
         next_q    <= pend_d;
         player_hp <= player_hp_d;
         enemy_hp  <= enemy_hp_d;
         // an event landing on this same frame start waits for the next one
         if (frame_start) begin
            state_q <= next_q;
            if (!settled)               frames <= '0;
            else if (frames != CNT_SAT) frames <= frames + CW'(1);
         end
      end
   end

   assign state_out     = state_q;
   assign player_hp_out = player_hp;
   assign enemy_hp_out  = enemy_hp;
   assign win_out       = (state_q == WIN);
   assign lose_out      = (state_q == LOSE);

endmodule

// File: tb/tb_battle_sequencer.sv
// Directed bench for battle_sequencer: a turn-level reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_battle_sequencer;

   localparam int FRAME_LEN = 8;   // 4 pixels x 2 lines per frame keeps runs short

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [10:0] hcount_in = '0;
   logic [9:0]  vcount_in = '0;
   logic        start_in = 1'b0, confirm_in = 1'b0;
   logic        atk_finished_in = 1'b0, dodge_finished_in = 1'b0;
   logic [7:0]  atk_damage_in = '0, dodge_damage_in = '0;
   logic [3:0]  state_out;
   logic [7:0]  player_hp_out, enemy_hp_out;
   logic        win_out, lose_out;

   int checks = 0;
   int errors = 0;
   int pos    = 0;

   battle_sequencer dut (
      .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
      .start_in(start_in), .confirm_in(confirm_in),
      .atk_finished_in(atk_finished_in), .atk_damage_in(atk_damage_in),
      .dodge_finished_in(dodge_finished_in), .dodge_damage_in(dodge_damage_in),
      .state_out(state_out), .player_hp_out(player_hp_out), .enemy_hp_out(enemy_hp_out),
      .win_out(win_out), .lose_out(lose_out)
   );

   always #5 clk = ~clk;

   // Reference model: turn rules in plain integer arithmetic
   localparam int S_IDLE = 0, S_ATK = 1, S_DODGE = 2, S_MENU = 4, S_WIN = 8, S_LOSE = 9;
   int m_shown = S_IDLE, m_pend = S_IDLE, m_php = 100, m_ehp = 200, m_frames = 0;

   always @(posedge clk) begin
      int np, nphp, nehp;
      if (!rst) begin
         m_shown = S_IDLE; m_pend = S_IDLE; m_php = 100; m_ehp = 200; m_frames = 0;
      end else begin
         np = m_pend; nphp = m_php; nehp = m_ehp;
         if (m_pend == m_shown) begin
            if ((m_shown == S_IDLE || m_shown == S_WIN || m_shown == S_LOSE) && start_in) begin
               nphp = 100; nehp = 200; np = S_MENU;
            end else if (m_shown == S_MENU && confirm_in && m_frames >= 30) begin
               np = S_ATK;
            end else if (m_shown == S_ATK && (atk_finished_in || m_frames >= 600)) begin
               nehp = m_ehp - (atk_finished_in ? int'(atk_damage_in) : 0);
               if (nehp < 0) nehp = 0;
               np = (nehp == 0) ? S_WIN : S_DODGE;
            end else if (m_shown == S_DODGE && (dodge_finished_in || m_frames >= 600)) begin
               nphp = m_php - (dodge_finished_in ? int'(dodge_damage_in) : 0);
               if (nphp < 0) nphp = 0;
               np = (nphp == 0) ? S_LOSE : S_MENU;
            end
         end
         if (hcount_in == 0 && vcount_in == 0) begin
            if (m_pend != m_shown) begin m_shown = m_pend; m_frames = 0; end
            else m_frames++;
         end
         m_pend = np; m_php = nphp; m_ehp = nehp;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model_state", int'(state_out), m_shown);
      chk("model_php", int'(player_hp_out), m_php);
      chk("model_ehp", int'(enemy_hp_out), m_ehp);
      chk("model_win", int'(win_out), int'(m_shown == S_WIN));
      chk("model_lose", int'(lose_out), int'(m_shown == S_LOSE));
   end

   // One clock: inputs were presented before the edge; pulses drop afterwards
   task automatic cyc();
      @(posedge clk);
      #1;
      start_in = 1'b0; confirm_in = 1'b0;
      atk_finished_in = 1'b0; dodge_finished_in = 1'b0;
      atk_damage_in = '0; dodge_damage_in = '0;
      pos = (pos + 1) % FRAME_LEN;
      hcount_in = 11'(pos % 4);
      vcount_in = 10'(pos / 4);
   endtask

   task automatic frames(input int n);
      repeat (n * FRAME_LEN) cyc();
   endtask

   // Run through the next frame-start edge
   task automatic to_fs();
      while (pos != 0) cyc();
      cyc();
   endtask

   task automatic go_attack();
      frames(31);
      confirm_in = 1'b1;
      cyc();
      to_fs();
   endtask

   task automatic hit(input int d);
      atk_finished_in = 1'b1; atk_damage_in = 8'(d);
      cyc();
      to_fs();
   endtask

   task automatic dodge(input int d);
      dodge_finished_in = 1'b1; dodge_damage_in = 8'(d);
      cyc();
      to_fs();
   endtask

   initial begin
      // 1: reset
      cyc(); cyc();
      chk("rst_state", int'(state_out), 0);
      chk("rst_php", int'(player_hp_out), 100);
      chk("rst_ehp", int'(enemy_hp_out), 200);
      chk("rst_win", int'(win_out), 0);
      chk("rst_lose", int'(lose_out), 0);
      rst = 1'b1;

      // 2: start mid-frame, early confirm ignored, late confirm accepted
      start_in = 1'b1;
      cyc();
      chk("start_held", int'(state_out), 0);
      to_fs();
      chk("start_menu", int'(state_out), 4'b0100);
      frames(5);
      confirm_in = 1'b1;
      cyc();
      to_fs();
      chk("early_confirm", int'(state_out), 4'b0100);
      frames(35);
      confirm_in = 1'b1;
      cyc();
      to_fs();
      chk("confirm_atk", int'(state_out), 4'b0001);

      // 3: one full round
      atk_finished_in = 1'b1; atk_damage_in = 8'd50;
      cyc();
      chk("atk50_ehp", int'(enemy_hp_out), 150);
      chk("atk50_held", int'(state_out), 4'b0001);
      to_fs();
      chk("to_dodge", int'(state_out), 4'b0010);
      dodge(30);
      chk("dodge30_php", int'(player_hp_out), 70);
      chk("to_menu", int'(state_out), 4'b0100);

      // 4: drive enemy to 20, then overkill saturates to 0 -> WIN, restart
      go_attack();
      hit(130);
      chk("ehp20", int'(enemy_hp_out), 20);
      dodge(0);
      go_attack();
      hit(255);
      chk("sat_ehp", int'(enemy_hp_out), 0);
      chk("win_state", int'(state_out), 4'b1000);
      chk("win_flag", int'(win_out), 1);
      start_in = 1'b1;
      cyc();
      chk("reload_php", int'(player_hp_out), 100);
      chk("reload_ehp", int'(enemy_hp_out), 200);
      to_fs();
      chk("restart_menu", int'(state_out), 4'b0100);
      start_in = 1'b1;   // ignored outside IDLE/WIN/LOSE
      cyc();

      // 5: attack timeout, then stray attack pulse during DODGE
      go_attack();
      frames(599);
      to_fs();
      chk("pre_timeout", int'(state_out), 4'b0001);
      to_fs();
      chk("timeout_dodge", int'(state_out), 4'b0010);
      chk("timeout_ehp", int'(enemy_hp_out), 200);
      atk_finished_in = 1'b1; atk_damage_in = 8'd50;
      cyc();
      chk("stray_ehp", int'(enemy_hp_out), 200);
      dodge(10);
      chk("dodge10_php", int'(player_hp_out), 90);

      // 6: double pulse, then reset mid-DODGE
      go_attack();
      atk_finished_in = 1'b1; atk_damage_in = 8'd10;
      cyc();
      atk_finished_in = 1'b1; atk_damage_in = 8'd10;
      cyc();
      chk("double_ehp", int'(enemy_hp_out), 190);
      to_fs();
      chk("double_dodge", int'(state_out), 4'b0010);
      rst = 1'b0;
      cyc();
      chk("midrst_state", int'(state_out), 0);
      chk("midrst_php", int'(player_hp_out), 100);
      rst = 1'b1;

      // LOSE path
      start_in = 1'b1;
      cyc();
      to_fs();
      go_attack();
      hit(1);
      dodge(200);
      chk("lose_php", int'(player_hp_out), 0);
      chk("lose_state", int'(state_out), 4'b1001);
      chk("lose_flag", int'(lose_out), 1);
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
